// File: rtl/writeback_unit.sv
// writeback_unit: in-order result buffer between the load/ALU units and the
// register-file write port. It also keeps a pending-write scoreboard.
// Load results take priority over ALU results, and at most one result is
// accepted per cycle. The write port is fully registered, so it holds steady
// across the falling edge where the register file samples it.
// Optional build macro WB_BYPASS_EN adds a combinational forwarding lookup
// (fwdReg_i / fwdHit_o / fwdData_o) over buffered and in-flight writes.
module writeback_unit #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       memValid_i,
  input  logic [2:0] memDest_i,
  input  logic [7:0] memData_i,
  output logic       memReady_o,
  input  logic       aluValid_i,
  input  logic [2:0] aluDest_i,
  input  logic [7:0] aluData_i,
  output logic       aluReady_o,
  input  logic       hold_i,
  input  logic       issueValid_i,
  input  logic [2:0] issueDest_i,
  output logic [7:0] busy_o,
  output logic       writeFlag_o,
  output logic [2:0] destReg_o,
  output logic [7:0] data_o
`ifdef WB_BYPASS_EN
  ,
  input  logic [2:0] fwdReg_i,
  output logic       fwdHit_o,
  output logic [7:0] fwdData_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [2:0]       dest_mem_q [DEPTH];
  logic [2:0]       dest_mem_d [DEPTH];
  logic [7:0]       data_mem_q [DEPTH];
  logic [7:0]       data_mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             write_flag_q, write_flag_d;
  logic [2:0]       dest_reg_q, dest_reg_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       busy_q, busy_d;

  logic full;
  logic push;
  logic pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake: ready only out of reset with space; ALU yields to the load unit.
  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    memReady_o = rst_n & ~full;
    aluReady_o = rst_n & ~full & ~memValid_i;
    push       = ~full & (memValid_i | aluValid_i);
    pop        = (count_q != '0) & ~hold_i;
  end

  // Buffer next state: enqueue at tail, pop head into the write port.
  always_comb begin
    dest_mem_d   = dest_mem_q;
    data_mem_d   = data_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    write_flag_d = 1'b0;
    dest_reg_d   = dest_reg_q;
    wr_data_d    = wr_data_q;
    if (push) begin
      dest_mem_d[wr_ptr_q] = memValid_i ? memDest_i : aluDest_i;
      data_mem_d[wr_ptr_q] = memValid_i ? memData_i : aluData_i;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      write_flag_d = 1'b1;
      dest_reg_d   = dest_mem_q[rd_ptr_q];
      wr_data_d    = data_mem_q[rd_ptr_q];
      rd_ptr_d     = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Scoreboard: clear on write-port load, then set on issue so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[dest_mem_q[rd_ptr_q]] = 1'b0;
    end
    if (issueValid_i) begin
      busy_d[issueDest_i] = 1'b1;
    end
  end

  // State registers; reset discards all buffered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dest_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      write_flag_q <= 1'b0;
      dest_reg_q   <= '0;
      wr_data_q    <= '0;
      busy_q       <= '0;
    end else begin
      dest_mem_q   <= dest_mem_d;
      data_mem_q   <= data_mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      write_flag_q <= write_flag_d;
      dest_reg_q   <= dest_reg_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
    end
  end

  assign writeFlag_o = write_flag_q;
  assign destReg_o   = dest_reg_q;
  assign data_o      = wr_data_q;
  assign busy_o      = busy_q;

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] fwd_idx;

  // Forwarding: the in-flight write is the oldest candidate; buffer entries are
  // scanned head to tail so the youngest match is left standing.
  always_comb begin
    fwdHit_o  = 1'b0;
    fwdData_o = '0;
    fwd_idx   = '0;
    if (write_flag_q && (dest_reg_q == fwdReg_i)) begin
      fwdHit_o  = 1'b1;
      fwdData_o = wr_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_q)) begin
        fwd_idx = PTR_W'((int'(rd_ptr_q) + i) % DEPTH);
        if (dest_mem_q[fwd_idx] == fwdReg_i) begin
          fwdHit_o  = 1'b1;
          fwdData_o = data_mem_q[fwd_idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit (DEPTH=2): a vector table applied one
// cycle per entry, plus hand-written reset and forwarding sequences.
module tb_writeback_unit;

  logic       clk;
  logic       rst_n;
  logic       memValid_i;
  logic [2:0] memDest_i;
  logic [7:0] memData_i;
  logic       memReady_o;
  logic       aluValid_i;
  logic [2:0] aluDest_i;
  logic [7:0] aluData_i;
  logic       aluReady_o;
  logic       hold_i;
  logic       issueValid_i;
  logic [2:0] issueDest_i;
  logic [7:0] busy_o;
  logic       writeFlag_o;
  logic [2:0] destReg_o;
  logic [7:0] data_o;
`ifdef WB_BYPASS_EN
  logic [2:0] fwdReg_i;
  logic       fwdHit_o;
  logic [7:0] fwdData_o;
`endif

  int checks = 0;
  int errors = 0;

  writeback_unit #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .memValid_i   (memValid_i),
    .memDest_i    (memDest_i),
    .memData_i    (memData_i),
    .memReady_o   (memReady_o),
    .aluValid_i   (aluValid_i),
    .aluDest_i    (aluDest_i),
    .aluData_i    (aluData_i),
    .aluReady_o   (aluReady_o),
    .hold_i       (hold_i),
    .issueValid_i (issueValid_i),
    .issueDest_i  (issueDest_i),
    .busy_o       (busy_o),
    .writeFlag_o  (writeFlag_o),
    .destReg_o    (destReg_o),
    .data_o       (data_o)
`ifdef WB_BYPASS_EN
    ,
    .fwdReg_i     (fwdReg_i),
    .fwdHit_o     (fwdHit_o),
    .fwdData_o    (fwdData_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mv;
    logic [2:0] md;
    logic [7:0] mdat;
    logic       av;
    logic [2:0] ad;
    logic [7:0] adat;
    logic       hold;
    logic       iv;
    logic [2:0] id;
    logic       e_mr;
    logic       e_ar;
    logic       e_wf;
    logic [2:0] e_dst;
    logic [7:0] e_dat;
    logic [7:0] e_busy;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(logic mv, logic [2:0] md, logic [7:0] mdat,
                              logic av, logic [2:0] ad, logic [7:0] adat,
                              logic hold, logic iv, logic [2:0] id,
                              logic e_mr, logic e_ar, logic e_wf,
                              logic [2:0] e_dst, logic [7:0] e_dat, logic [7:0] e_busy);
    vec_t v;
    v.mv = mv; v.md = md; v.mdat = mdat;
    v.av = av; v.ad = ad; v.adat = adat;
    v.hold = hold; v.iv = iv; v.id = id;
    v.e_mr = e_mr; v.e_ar = e_ar; v.e_wf = e_wf;
    v.e_dst = e_dst; v.e_dat = e_dat; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    memValid_i   = v.mv;
    memDest_i    = v.md;
    memData_i    = v.mdat;
    aluValid_i   = v.av;
    aluDest_i    = v.ad;
    aluData_i    = v.adat;
    hold_i       = v.hold;
    issueValid_i = v.iv;
    issueDest_i  = v.id;
  endtask

  vec_t idle;

  initial begin
    //                mv md mdat   av ad adat   hd iv id  | mr ar wf dst dat   busy
    vecs[0]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0,  1, 1, 0, 0, 8'h00, 8'h00);
    // single ALU result, one-cycle latency and one-cycle pulse; issue reg3
    vecs[1]  = mk(0, 0, 8'h00, 1, 3, 8'h5A, 0, 1, 3,  1, 1, 0, 0, 8'h00, 8'h08);
    vecs[2]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0,  1, 1, 1, 3, 8'h5A, 8'h00);
    vecs[3]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0,  1, 1, 0, 3, 8'h5A, 8'h00);
    // load and ALU offered together: load first, ALU held then accepted
    vecs[4]  = mk(1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0,  1, 0, 0, 3, 8'h5A, 8'h00);
    vecs[5]  = mk(0, 0, 8'h00, 1, 2, 8'h22, 0, 0, 0,  1, 1, 1, 1, 8'h11, 8'h00);
    vecs[6]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0,  1, 1, 1, 2, 8'h22, 8'h00);
    vecs[7]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0,  1, 1, 0, 2, 8'h22, 8'h00);
    // scoreboard: issue reg5 at N, write loaded at N+3 alongside a re-issue
    vecs[8]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 5,  1, 1, 0, 2, 8'h22, 8'h20);
    vecs[9]  = mk(0, 0, 8'h00, 1, 5, 8'h55, 0, 0, 0,  1, 1, 0, 2, 8'h22, 8'h20);
    vecs[10] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0,  1, 1, 0, 2, 8'h22, 8'h20);
    vecs[11] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 5,  1, 1, 1, 5, 8'h55, 8'h20);
    vecs[12] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0,  1, 1, 0, 5, 8'h55, 8'h20);
    vecs[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 5,  1, 1, 0, 5, 8'h55, 8'h20);
    vecs[14] = mk(0, 0, 8'h00, 1, 5, 8'h66, 0, 0, 0,  1, 1, 0, 5, 8'h55, 8'h20);
    vecs[15] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0,  1, 1, 1, 5, 8'h66, 8'h00);
    // hold with three offers: two accepted, full, then drain in order
    vecs[16] = mk(0, 0, 8'h00, 1, 4, 8'h10, 1, 0, 0,  1, 1, 0, 5, 8'h66, 8'h00);
    vecs[17] = mk(0, 0, 8'h00, 1, 4, 8'h20, 1, 0, 0,  1, 1, 0, 5, 8'h66, 8'h00);
    vecs[18] = mk(0, 0, 8'h00, 1, 7, 8'h77, 1, 0, 0,  0, 0, 0, 5, 8'h66, 8'h00);
    vecs[19] = mk(0, 0, 8'h00, 1, 7, 8'h77, 0, 0, 0,  0, 0, 1, 4, 8'h10, 8'h00);
    vecs[20] = mk(0, 0, 8'h00, 1, 7, 8'h77, 0, 0, 0,  1, 1, 1, 4, 8'h20, 8'h00);
    vecs[21] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0,  1, 1, 1, 7, 8'h77, 8'h00);
    vecs[22] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0,  1, 1, 0, 7, 8'h77, 8'h00);
    idle = vecs[0];

    rst_n = 1'b0;
    drive(idle);
`ifdef WB_BYPASS_EN
    fwdReg_i = 3'd0;
`endif
    #12;
    check("rst_mem_ready", 8'(memReady_o), 8'h00);
    check("rst_alu_ready", 8'(aluReady_o), 8'h00);
    check("rst_wflag", 8'(writeFlag_o), 8'h00);
    check("rst_dest", 8'(destReg_o), 8'h00);
    check("rst_data", data_o, 8'h00);
    check("rst_busy", busy_o, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_mem_ready", 8'(memReady_o), 8'h01);
    check("rel_alu_ready", 8'(aluReady_o), 8'h01);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_mem_ready", i), 8'(memReady_o), 8'(vecs[i].e_mr));
      check($sformatf("v%0d_alu_ready", i), 8'(aluReady_o), 8'(vecs[i].e_ar));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wflag", i), 8'(writeFlag_o), 8'(vecs[i].e_wf));
      check($sformatf("v%0d_dest", i), 8'(destReg_o), 8'(vecs[i].e_dst));
      check($sformatf("v%0d_data", i), data_o, vecs[i].e_dat);
      check($sformatf("v%0d_busy", i), busy_o, vecs[i].e_busy);
    end

    // Mid-operation reset with two results buffered.
    @(negedge clk);
    drive(mk(0, 0, 8'h00, 1, 1, 8'h01, 1, 1, 6, 0, 0, 0, 0, 8'h00, 8'h00));
    @(negedge clk);
    drive(mk(0, 0, 8'h00, 1, 2, 8'h02, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    @(negedge clk);
    drive(idle);
    check("pre_rst_busy", busy_o, 8'h40);
    check("pre_rst_full", 8'(memReady_o), 8'h00);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wflag", 8'(writeFlag_o), 8'h00);
    check("mid_rst_dest", 8'(destReg_o), 8'h00);
    check("mid_rst_data", data_o, 8'h00);
    check("mid_rst_busy", busy_o, 8'h00);
    check("mid_rst_mem_ready", 8'(memReady_o), 8'h00);
    check("mid_rst_alu_ready", 8'(aluReady_o), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_mem_ready", 8'(memReady_o), 8'h01);
    check("post_rst_alu_ready", 8'(aluReady_o), 8'h01);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_wflag_c%0d", c), 8'(writeFlag_o), 8'h00);
      check($sformatf("post_rst_busy_c%0d", c), busy_o, 8'h00);
    end

`ifdef WB_BYPASS_EN
    // Forwarding: two writes to reg4 buffered, youngest data wins.
    @(negedge clk);
    drive(mk(0, 0, 8'h00, 1, 4, 8'h10, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    @(negedge clk);
    drive(mk(0, 0, 8'h00, 1, 4, 8'h20, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    @(negedge clk);
    drive(mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    fwdReg_i = 3'd4;
    #1;
    check("fwd4_hit", 8'(fwdHit_o), 8'h01);
    check("fwd4_data", fwdData_o, 8'h20);
    fwdReg_i = 3'd6;
    #1;
    check("fwd6_hit", 8'(fwdHit_o), 8'h00);
    check("fwd6_data", fwdData_o, 8'h00);
    @(negedge clk);
    drive(idle);
    @(posedge clk);
    #1;
    fwdReg_i = 3'd4;
    #1;
    check("fwd_inflight_hit", 8'(fwdHit_o), 8'h01);
    check("fwd_inflight_data", fwdData_o, 8'h20);
    repeat (3) @(posedge clk);
    #1;
    check("fwd_drained_hit", 8'(fwdHit_o), 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DEPTH, default 2: result buffer entries; legal range 2..8.
REQ-002 Port clk  in  1: single clock; all state on rising edge.
REQ-003 Port rst_n  in  1: asynchronous, active-low reset.
REQ-004 Port memValid_i / memDest_i / memData_i  in  1/3/8: load-unit result offer.
REQ-005 Port memReady_o  out  1: load result accepted when memValid_i && memReady_o at rising edge.
REQ-006 Port aluValid_i / aluDest_i / aluData_i  in  1/3/8: ALU result offer.
REQ-007 Port aluReady_o  out  1: ALU result accepted when aluValid_i && aluReady_o at rising edge.
REQ-008 Port hold_i  in  1: high blocks draining the buffer this cycle.
REQ-009 Port issueValid_i / issueDest_i  in  1/3: decode reserves destination register.
REQ-010 Port busy_o  out  8: scoreboard, bit r = write to register r pending.
REQ-011 Port writeFlag_o / destReg_o / data_o  out  1/3/8: register-file write port.

Function
REQ-012 memReady_o SHALL be (buffer not full); aluReady_o SHALL be (buffer not full) && !memValid_i; load results have fixed priority.
REQ-013 At most one result SHALL be enqueued per cycle; buffer is in-order FIFO of {dest, data}.
REQ-014 Each rising edge with buffer non-empty and hold_i low SHALL pop the head into registered outputs: writeFlag_o=1, destReg_o/data_o = head, for exactly one cycle.
REQ-015 Otherwise writeFlag_o SHALL be 0 next cycle; destReg_o/data_o hold previous values.
REQ-016 Latency: result accepted at edge N into empty buffer, hold_i low -> writeFlag_o high from edge N+1 to edge N+2.
REQ-017 Outputs SHALL be registered only (no combinational path from inputs), so they are stable across the falling edge where the register file samples them.
REQ-018 Enqueue and pop in the same cycle SHALL both occur; occupancy unchanged.
REQ-019 Full buffer: both ready outputs low; offers held by sources, no loss, no overwrite.
REQ-020 Same destination queued twice: both writes issued in acceptance order; last data wins.
REQ-021 busy_o[issueDest_i] SHALL set at edge where issueValid_i high; bit cleared at edge that loads a write to that register into outputs.
REQ-022 Set and clear of same bit at same edge: set wins (bit stays 1).
REQ-023 issueValid_i to an already-busy register: bit stays 1; no error.

Reset
REQ-024 While rst_n low: writeFlag_o=0, destReg_o=0, data_o=0, busy_o=0, buffer empty, memReady_o=0, aluReady_o=0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered results with no write pulse; first write after release requires a new accepted result.
REQ-026 After release, ready outputs SHALL be high in the first cycle (buffer empty).

Configuration
REQ-027 Macro WB_BYPASS_EN defined: ports fwdReg_i (in 3), fwdHit_o (out 1), fwdData_o (out 8) exist; fwdHit_o=1 when any buffered entry or the current output entry (writeFlag_o high) targets fwdReg_i; fwdData_o = youngest match, else 0; combinational.
REQ-028 Macro undefined: bypass ports and logic absent; all other behaviour identical.

Verification
REQ-029 Single ALU result dest=3 data=0x5A, empty buffer -> writeFlag_o=1, destReg_o=3, data_o=0x5A one cycle after acceptance, one cycle wide.
REQ-030 memValid_i and aluValid_i high same cycle (dest 1/0x11, dest 2/0x22) -> mem accepted first, aluReady_o low; writes issued reg1 then reg2.
REQ-031 hold_i high, DEPTH=2, three ALU offers -> two accepted, both ready low, no writes; hold_i low -> two writes back-to-back, third accepted.
REQ-032 issueValid_i dest=5 at edge N, write to reg5 loaded at N+3 while issueValid_i dest=5 again -> busy_o[5] stays 1.
REQ-033 Two entries buffered, rst_n pulsed low -> outputs/busy_o zero, no writeFlag_o pulse after release.
REQ-034 WB_BYPASS_EN: buffer holds reg4=0x10 then reg4=0x20, fwdReg_i=4 -> fwdHit_o=1, fwdData_o=0x20; fwdReg_i=6 -> fwdHit_o=0, fwdData_o=0.
